// File: rtl/protocol_rx_parser.sv
// protocol_rx_parser: receive-side message parser for the radiation-sensor link.
// Checks the 4-byte magic, captures the command byte and argument bytes, and
// issues a one-cycle msg_valid with decoded fields, error flag and reply length.
// Optional build macro: PROTOCOL_RX_PARSER_STATS_EN adds the stat_rx_ok and
// stat_rx_dropped saturating message counters.
module protocol_rx_parser #(
    parameter logic [31:0] MAGIC       = 32'hF100BA00,
    parameter int          RX_BUFF_LEN = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_soc,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_eoc,
    input  logic        rx_error,
    output logic        msg_valid,
    output logic [7:0]  cmd,
    output logic        cmd_error,
    output logic [3:0]  reply_len,
    output logic [15:0] sync,
    output logic [7:0]  sig_mask,
    output logic [7:0]  sig_value,
    output logic [31:0] timing1,
    output logic [31:0] timing2,
    output logic        busy
`ifdef PROTOCOL_RX_PARSER_STATS_EN
    ,
    output logic [7:0]  stat_rx_ok,
    output logic [7:0]  stat_rx_dropped
`endif
);

    // Argument bytes are those after magic (4) and cmd (1).
    localparam int ARG_LEN = RX_BUFF_LEN - 5;
    localparam int ARG_W   = ARG_LEN * 8;

    localparam logic [7:0] CMD_IDENTIFY   = 8'h00;
    localparam logic [7:0] CMD_SET_SIGNAL = 8'h01;
    localparam logic [7:0] CMD_AUTO_READ  = 8'h02;
    localparam logic [7:0] CMD_GET_RESULT = 8'h03;
    localparam logic [7:0] CMD_ABORT      = 8'h04;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_DECODE  = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        cmd_byte_q, cmd_byte_d;
    // Argument buffer, byte 5 of the message in the most significant position.
    logic [ARG_W-1:0]  args_q, args_d;
    logic              restart_s;
    logic              magic_bad_s;

    logic              msg_valid_q;
    logic [7:0]        cmd_q;
    logic              cmd_error_q;
    logic [3:0]        reply_len_q;
    logic [15:0]       sync_q;
    logic [7:0]        sig_mask_q;
    logic [7:0]        sig_value_q;
    logic [31:0]       timing1_q;
    logic [31:0]       timing2_q;
    logic              busy_q;

    logic              msg_fire_s;
    logic              known_s;
    logic [4:0]        req_len_s;
    logic [3:0]        dec_reply_s;
    logic              dec_err_s;
    logic [15:0]       dec_sync_s;
    logic [7:0]        dec_mask_s;
    logic [7:0]        dec_value_s;
    logic [31:0]       dec_t1_s;
    logic [31:0]       dec_t2_s;

    // Expected magic byte for a given position, MSB first.
    function automatic logic [7:0] magic_byte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = MAGIC[31:24];
            2'd1:    b = MAGIC[23:16];
            2'd2:    b = MAGIC[15:8];
            2'd3:    b = MAGIC[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Byte counter, magic check and storage of cmd/argument bytes.
    always_comb begin
        cnt_d       = cnt_q;
        cmd_byte_d  = cmd_byte_q;
        args_d      = args_q;
        magic_bad_s = 1'b0;
        restart_s   = rx_soc && (state_q != ST_DECODE);
        if (restart_s) begin
            cnt_d      = 5'd0;
            cmd_byte_d = 8'h00;
            args_d     = '0;
        end else if ((state_q == ST_RECV) && rx_data_valid) begin
            cnt_d = (cnt_q == 5'd31) ? cnt_q : (cnt_q + 5'd1);
            if (cnt_q < 5'd4) begin
                magic_bad_s = (rx_data != magic_byte(cnt_q[1:0]));
            end else if (cnt_q == 5'd4) begin
                cmd_byte_d = rx_data;
            end else begin
                for (int i = 0; i < ARG_LEN; i++) begin
                    if (int'(cnt_q) == i + 5) begin
                        args_d[8*(ARG_LEN-1-i) +: 8] = rx_data;
                    end else begin
                        args_d[8*(ARG_LEN-1-i) +: 8] = args_d[8*(ARG_LEN-1-i) +: 8];
                    end
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; same-cycle byte is already folded into cnt_d.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_soc) state_d = ST_RECV;
                else        state_d = ST_IDLE;
            end
            ST_RECV: begin
                if (rx_soc)                    state_d = ST_RECV;
                else if (rx_error)             state_d = ST_DISCARD;
                else if (magic_bad_s)          state_d = ST_DISCARD;
                else if (rx_eoc && cnt_d < 5'd5) state_d = ST_DISCARD;
                else if (rx_eoc)               state_d = ST_DECODE;
                else                           state_d = ST_RECV;
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
            end
            ST_DISCARD: begin
                if (rx_soc)      state_d = ST_RECV;
                else if (rx_eoc) state_d = ST_IDLE;
                else             state_d = ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: decode of the completed message, captured on entry to DECODE.
    always_comb begin
        msg_fire_s  = (state_q == ST_RECV) && (state_d == ST_DECODE);
        known_s     = 1'b1;
        req_len_s   = 5'd7;
        dec_reply_s = 4'd6;
        dec_sync_s  = 16'h0000;
        dec_mask_s  = 8'h00;
        dec_value_s = 8'h00;
        dec_t1_s    = 32'h0000_0000;
        dec_t2_s    = 32'h0000_0000;
        case (cmd_byte_d)
            CMD_IDENTIFY: begin
                req_len_s   = 5'd7;
                dec_reply_s = 4'd10;
            end
            CMD_SET_SIGNAL: begin
                req_len_s   = 5'd11;
                dec_sync_s  = args_d[ARG_W-1  -: 16];
                dec_mask_s  = args_d[ARG_W-17 -: 8];
                dec_value_s = args_d[ARG_W-25 -: 8];
            end
            CMD_AUTO_READ: begin
                req_len_s  = 5'd17;
                dec_sync_s = args_d[ARG_W-1  -: 16];
                dec_t1_s   = args_d[ARG_W-17 -: 32];
                dec_t2_s   = args_d[ARG_W-49 -: 32];
            end
            CMD_GET_RESULT: begin
                req_len_s   = 5'd7;
                dec_reply_s = 4'd8;
            end
            CMD_ABORT: begin
                req_len_s = 5'd7;
            end
            default: begin
                known_s     = 1'b0;
                dec_reply_s = 4'd6;
            end
        endcase
        dec_err_s = !known_s || (cnt_d != req_len_s);
    end

    // Receive datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 5'd0;
            cmd_byte_q <= 8'h00;
            args_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cmd_byte_q <= cmd_byte_d;
            args_q     <= args_d;
        end
    end

    // Registered outputs; decoded fields change only with msg_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_valid_q <= 1'b0;
            cmd_q       <= 8'h00;
            cmd_error_q <= 1'b0;
            reply_len_q <= 4'd0;
            sync_q      <= 16'h0000;
            sig_mask_q  <= 8'h00;
            sig_value_q <= 8'h00;
            timing1_q   <= 32'h0000_0000;
            timing2_q   <= 32'h0000_0000;
            busy_q      <= 1'b0;
        end else begin
            msg_valid_q <= msg_fire_s;
            busy_q      <= (state_d == ST_RECV) || (state_d == ST_DISCARD);
            if (msg_fire_s) begin
                cmd_q       <= cmd_byte_d;
                cmd_error_q <= dec_err_s;
                reply_len_q <= dec_reply_s;
                sync_q      <= dec_sync_s;
                sig_mask_q  <= dec_mask_s;
                sig_value_q <= dec_value_s;
                timing1_q   <= dec_t1_s;
                timing2_q   <= dec_t2_s;
            end
        end
    end

    assign msg_valid = msg_valid_q;
    assign cmd       = cmd_q;
    assign cmd_error = cmd_error_q;
    assign reply_len = reply_len_q;
    assign sync      = sync_q;
    assign sig_mask  = sig_mask_q;
    assign sig_value = sig_value_q;
    assign timing1   = timing1_q;
    assign timing2   = timing2_q;
    assign busy      = busy_q;

`ifdef PROTOCOL_RX_PARSER_STATS_EN
    logic [7:0] stat_ok_q;
    logic [7:0] stat_drop_q;
    logic       drop_event_s;

    assign drop_event_s = ((state_d == ST_DISCARD) && (state_q != ST_DISCARD)) ||
                          ((state_q == ST_RECV) && rx_soc);

    // Saturating good-message and dropped-message counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok_q   <= 8'h00;
            stat_drop_q <= 8'h00;
        end else begin
            if (msg_fire_s && (stat_ok_q != 8'hFF)) begin
                stat_ok_q <= stat_ok_q + 8'h01;
            end
            if (drop_event_s && (stat_drop_q != 8'hFF)) begin
                stat_drop_q <= stat_drop_q + 8'h01;
            end
        end
    end

    assign stat_rx_ok      = stat_ok_q;
    assign stat_rx_dropped = stat_drop_q;
`endif

endmodule

// File: doc/protocol_rx_parser.md
Name: protocol_rx_parser

Overview:
- Sits between the ISO/IEC 14443-4 receive interface and the radiation-sensor application controller.
- Consumes the per-message byte stream, which includes the 2 CRC bytes. Checks PROTOCOL_MAGIC, then decodes the command and its arguments into fixed fields.
- Issues a single-cycle msg_valid pulse that carries an error flag and the required reply length, so the controller can build the reply without re-parsing.

Parameters:
- MAGIC, 32'hF100BA00, expected magic; received MSB byte first.
- RX_BUFF_LEN, 15, bytes stored (magic + cmd + longest args); later bytes are counted but not stored.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- rx_soc  input  1  start of message pulse.
- rx_data  input  8  received byte.
- rx_data_valid  input  1  rx_data valid this cycle.
- rx_eoc  input  1  end of message pulse.
- rx_error  input  1  CRC/framing error on current message.
- msg_valid  output  1  one-cycle pulse: decoded message available.
- cmd  output  8  received command byte.
- cmd_error  output  1  unknown command or length mismatch.
- reply_len  output  4  reply length: 10 for IDENTIFY, 8 for GET_RESULT, 6 otherwise.
- sync  output  16  SET_SIGNAL/AUTO_READ sync argument.
- sig_mask  output  8  SET_SIGNAL mask.
- sig_value  output  8  SET_SIGNAL value.
- timing1  output  32  AUTO_READ timing1.
- timing2  output  32  AUTO_READ timing2.
- busy  output  1  message in progress (between rx_soc and rx_eoc).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; byte counter 0.
- FSM states: IDLE -> RECV on rx_soc.
  - RECV -> DECODE on rx_eoc.
  - RECV -> DISCARD on rx_error, on a magic mismatch at any of bytes 0-3, or on rx_eoc with count < 5.
  - DECODE -> IDLE after 1 cycle.
  - DISCARD -> IDLE on rx_eoc. From DISCARD, rx_soc goes to RECV.
- Byte counter: 5 bits, incremented per rx_data_valid in RECV, saturates at 31. Counts CRC bytes.
  - Bytes 0-3 are compared against MAGIC[31:24]..MAGIC[7:0] as they arrive.
  - Byte 4 is cmd. Bytes 5..14 fill the arg buffer; bytes at index >= RX_BUFF_LEN are not stored.
- Arg mapping, all multi-byte fields MSB first:
  - SET_SIGNAL: sync = bytes 5-6, sig_mask = byte 7, sig_value = byte 8.
  - AUTO_READ: sync = bytes 5-6, timing1 = bytes 7-10, timing2 = bytes 11-14.
- DECODE: msg_valid = 1 for exactly one cycle, on the cycle after rx_eoc.
  - cmd_error = 1 if cmd > 8'h04, or if count != required length (IDENTIFY 7, SET_SIGNAL 11, AUTO_READ 17, GET_RESULT 7, ABORT 7).
  - reply_len is from cmd when cmd is known. For an unknown cmd it is 6.
- DISCARD produces no msg_valid. The message is not ours or is corrupt, so no reply is sent.
- Output fields update only on the msg_valid cycle and hold until the next msg_valid.
  - Arg fields not used by the command are 0.
  - On cmd_error the arg fields are still presented, holding whatever was stored.
- Same-cycle events:
  - rx_data_valid with rx_eoc: the byte is counted and stored first, then rx_eoc is evaluated.
  - rx_error in the same cycle as rx_eoc: the message is discarded.
  - rx_soc while in RECV: the current message is abandoned silently, the counter resets, and reception restarts.
- rx_data_valid outside RECV is ignored. rx_eoc in IDLE is ignored.
- busy = 1 in RECV and DISCARD.
- Asserting rst mid-message returns the FSM to IDLE immediately. No msg_valid is issued for that message.

Optional Feature:
- PROTOCOL_RX_PARSER_STATS_EN: adds output ports stat_rx_ok[7:0] and stat_rx_dropped[7:0]. Both are 8-bit saturating counters, reset to 0.
  - stat_rx_ok increments on each msg_valid.
  - stat_rx_dropped increments on each entry into DISCARD and on each abandoned RECV (new rx_soc).
- Without the macro, these ports and counters do not exist.

Test Plan:
- SET_SIGNAL: F1 00 BA 00 01 12 34 A5 5A + 2 CRC bytes, then eoc -> msg_valid 1 cycle later; cmd=01, cmd_error=0, reply_len=6, sync=16'h1234, sig_mask=A5, sig_value=5A.
- AUTO_READ, 17 bytes: F1 00 BA 00 02 00 10 00 00 00 FF 01 02 03 04 + CRC -> cmd_error=0, reply_len=6, sync=16'h0010, timing1=32'h000000FF, timing2=32'h01020304.
- IDENTIFY with bad magic, F1 00 BB 00 00 + CRC -> no msg_valid, busy held until eoc. IDENTIFY with good magic -> reply_len=10, cmd_error=0.
- GET_RESULT with 9 bytes -> cmd_error=1, reply_len=8. Unknown cmd 07 with 7 bytes -> cmd_error=1, reply_len=6.
- rx_error during byte 6 of SET_SIGNAL -> no msg_valid, and outputs keep the previous message's values. rx_soc mid-message followed by a valid ABORT -> a single msg_valid with cmd=04.
- rst asserted at byte 3 -> all outputs 0 and no msg_valid. With PROTOCOL_RX_PARSER_STATS_EN: 300 good messages -> stat_rx_ok=255, saturated.
